// File: rtl/manta_bus_arbiter.sv
// -----------------------------------------------------------------------------
// manta_bus_arbiter
//
// Purpose: two-master round-robin arbiter for the 16-bit Manta register bus.
// Each master owns a one-entry pending buffer. Buffered requests are granted
// one at a time onto the daisy-chained core bus. The transaction returning
// from the end of the chain is routed back to the master that issued it.
//
// Handshake: there is no back-pressure anywhere. Every *_valid signal is a
// single-cycle pulse that carries its payload in that same cycle. A request
// pulse is either buffered or, when the buffer is still occupied, dropped and
// recorded in the sticky mX_drop_o flag.
//
// Ports:
//   clk, rst_n                      clock; synchronous active-low reset
//   m{0,1}_addr_i/_data_i/_rw_i     request fields (rw: 1 = write)
//   m{0,1}_valid_i                  request pulse
//   m{0,1}_data_o/_rw_o/_valid_o    response to that master
//   m{0,1}_drop_o                   sticky overflow flag
//   bus_addr_o/_data_o/_rw_o        transaction to the core chain (held)
//   bus_valid_o                     transaction pulse
//   ret_addr_i/_data_i/_rw_i        transaction returning from the chain
//   ret_valid_i                     return pulse
//   timeout_o                       pulse when a transaction is abandoned
//
// Optional feature: define ARB_TIMEOUT_EN to abandon a transaction after
// TIMEOUT_CYCLES cycles in WAIT. Without it, WAIT lasts until a return.
// -----------------------------------------------------------------------------
module manta_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] m0_addr_i,
   input  logic [15:0] m0_data_i,
   input  logic        m0_rw_i,
   input  logic        m0_valid_i,
   output logic [15:0] m0_data_o,
   output logic        m0_rw_o,
   output logic        m0_valid_o,
   output logic        m0_drop_o,
   input  logic [15:0] m1_addr_i,
   input  logic [15:0] m1_data_i,
   input  logic        m1_rw_i,
   input  logic        m1_valid_i,
   output logic [15:0] m1_data_o,
   output logic        m1_rw_o,
   output logic        m1_valid_o,
   output logic        m1_drop_o,
   output logic [15:0] bus_addr_o,
   output logic [15:0] bus_data_o,
   output logic        bus_rw_o,
   output logic        bus_valid_o,
   input  logic [15:0] ret_addr_i,
   input  logic [15:0] ret_data_i,
   input  logic        ret_rw_i,
   input  logic        ret_valid_i,
   output logic        timeout_o
);

   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

   state_e      state_q, state_d;
   logic [1:0]  pend_q, pend_d;
   logic [15:0] buf_addr_q [2];
   logic [15:0] buf_addr_d [2];
   logic [15:0] buf_data_q [2];
   logic [15:0] buf_data_d [2];
   logic [1:0]  buf_rw_q, buf_rw_d;
   logic [1:0]  drop_q, drop_d;
   logic        last_q, last_d;
   logic        owner_q, owner_d;
   logic [15:0] bus_addr_q, bus_addr_d, bus_data_q, bus_data_d;
   logic        bus_rw_q, bus_rw_d, bus_valid_q, bus_valid_d;
   logic [15:0] rsp_data_q [2];
   logic [15:0] rsp_data_d [2];
   logic [1:0]  rsp_rw_q, rsp_rw_d, rsp_valid_q, rsp_valid_d;
   logic        timeout_q, timeout_d;
   logic        grant_en;
   logic        grant_sel;

   // Request inputs gathered per master so both buffers share one code path.
   logic [15:0] req_addr [2];
   logic [15:0] req_data [2];
   logic [1:0]  req_rw, req_valid;
   assign req_addr[0] = m0_addr_i;
   assign req_addr[1] = m1_addr_i;
   assign req_data[0] = m0_data_i;
   assign req_data[1] = m1_data_i;
   assign req_rw      = {m1_rw_i, m0_rw_i};
   assign req_valid   = {m1_valid_i, m0_valid_i};

`ifdef ARB_TIMEOUT_EN
   logic [15:0] cnt_q, cnt_d;
   logic [16:0] cnt_inc;
   assign cnt_inc = {1'b0, cnt_q} + 17'd1;
`endif

   // The return address is never inspected: with a single outstanding
   // transaction the owner is already known.
   logic unused_sink;
   assign unused_sink = ^{ret_addr_i, 16'(TIMEOUT_CYCLES)};

   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      buf_rw_d    = buf_rw_q;
      drop_d      = drop_q;
      last_d      = last_q;
      owner_d     = owner_q;
      bus_addr_d  = bus_addr_q;
      bus_data_d  = bus_data_q;
      bus_rw_d    = bus_rw_q;
      bus_valid_d = 1'b0;
      rsp_rw_d    = rsp_rw_q;
      rsp_valid_d = 2'b00;
      timeout_d   = 1'b0;
      grant_en    = 1'b0;
      grant_sel   = 1'b0;
      for (int i = 0; i < 2; i++) begin
         buf_addr_d[i] = buf_addr_q[i];
         buf_data_d[i] = buf_data_q[i];
         rsp_data_d[i] = rsp_data_q[i];
      end
`ifdef ARB_TIMEOUT_EN
      cnt_d = cnt_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (|pend_q) begin
               grant_en = 1'b1;
               // On a tie the master not granted last time wins; otherwise
               // the single pending master is selected.
               grant_sel = (&pend_q) ? ~last_q : pend_q[1];
               bus_addr_d  = buf_addr_q[grant_sel];
               bus_data_d  = buf_data_q[grant_sel];
               bus_rw_d    = buf_rw_q[grant_sel];
               bus_valid_d = 1'b1;
               owner_d     = grant_sel;
               last_d      = grant_sel;
               state_d     = S_WAIT;
`ifdef ARB_TIMEOUT_EN
               cnt_d = 16'd0;
`endif
            end
         end
         S_WAIT: begin
            if (ret_valid_i) begin
               rsp_data_d[owner_q]  = ret_data_i;
               rsp_rw_d[owner_q]    = ret_rw_i;
               rsp_valid_d[owner_q] = 1'b1;
               state_d              = S_IDLE;
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_inc == 17'(TIMEOUT_CYCLES)) begin
               // Abandoned: answer the owner with zero data and the type
               // that was issued, which bus_rw_q still holds.
               rsp_data_d[owner_q]  = 16'h0000;
               rsp_rw_d[owner_q]    = bus_rw_q;
               rsp_valid_d[owner_q] = 1'b1;
               timeout_d            = 1'b1;
               state_d              = S_IDLE;
            end else begin
               cnt_d = cnt_inc[15:0];
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase

      // Buffer intake. The grant clears pend first, so a pulse in the grant
      // cycle reloads the buffer instead of being dropped.
      for (int i = 0; i < 2; i++) begin
         if (grant_en && (grant_sel == i[0])) begin
            pend_d[i] = 1'b0;
         end
         if (req_valid[i]) begin
            if (pend_d[i]) begin
               drop_d[i] = 1'b1;
            end else begin
               pend_d[i]     = 1'b1;
               buf_addr_d[i] = req_addr[i];
               buf_data_d[i] = req_data[i];
               buf_rw_d[i]   = req_rw[i];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         pend_q      <= 2'b00;
         buf_rw_q    <= 2'b00;
         drop_q      <= 2'b00;
         last_q      <= 1'b1;
         owner_q     <= 1'b0;
         bus_addr_q  <= 16'h0000;
         bus_data_q  <= 16'h0000;
         bus_rw_q    <= 1'b0;
         bus_valid_q <= 1'b0;
         rsp_rw_q    <= 2'b00;
         rsp_valid_q <= 2'b00;
         timeout_q   <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            buf_addr_q[i] <= 16'h0000;
            buf_data_q[i] <= 16'h0000;
            rsp_data_q[i] <= 16'h0000;
         end
`ifdef ARB_TIMEOUT_EN
         cnt_q <= 16'd0;
`endif
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         buf_rw_q    <= buf_rw_d;
         drop_q      <= drop_d;
         last_q      <= last_d;
         owner_q     <= owner_d;
         bus_addr_q  <= bus_addr_d;
         bus_data_q  <= bus_data_d;
         bus_rw_q    <= bus_rw_d;
         bus_valid_q <= bus_valid_d;
         rsp_rw_q    <= rsp_rw_d;
         rsp_valid_q <= rsp_valid_d;
         timeout_q   <= timeout_d;
         for (int i = 0; i < 2; i++) begin
            buf_addr_q[i] <= buf_addr_d[i];
            buf_data_q[i] <= buf_data_d[i];
            rsp_data_q[i] <= rsp_data_d[i];
         end
`ifdef ARB_TIMEOUT_EN
         cnt_q <= cnt_d;
`endif
      end
   end

   assign m0_data_o   = rsp_data_q[0];
   assign m0_rw_o     = rsp_rw_q[0];
   assign m0_valid_o  = rsp_valid_q[0];
   assign m0_drop_o   = drop_q[0];
   assign m1_data_o   = rsp_data_q[1];
   assign m1_rw_o     = rsp_rw_q[1];
   assign m1_valid_o  = rsp_valid_q[1];
   assign m1_drop_o   = drop_q[1];
   assign bus_addr_o  = bus_addr_q;
   assign bus_data_o  = bus_data_q;
   assign bus_rw_o    = bus_rw_q;
   assign bus_valid_o = bus_valid_q;
   assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_manta_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_manta_bus_arbiter
//
// Bench for manta_bus_arbiter. A transaction-level model (pending slots,
// one outstanding owner, round-robin pick) predicts every output each cycle.
// Directed scenarios with literal expectations are followed by a randomized
// phase. Responses are also tracked through an expected queue.
// -----------------------------------------------------------------------------
module tb_manta_bus_arbiter;

`ifdef ARB_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 255;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic [15:0] m0_addr_i, m0_data_i, m1_addr_i, m1_data_i;
   logic        m0_rw_i, m0_valid_i, m1_rw_i, m1_valid_i;
   logic [15:0] m0_data_o, m1_data_o;
   logic        m0_rw_o, m0_valid_o, m0_drop_o, m1_rw_o, m1_valid_o, m1_drop_o;
   logic [15:0] bus_addr_o, bus_data_o;
   logic        bus_rw_o, bus_valid_o;
   logic [15:0] ret_addr_i, ret_data_i;
   logic        ret_rw_i, ret_valid_i;
   logic        timeout_o;

   manta_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_rw_i(m0_rw_i),
      .m0_valid_i(m0_valid_i), .m0_data_o(m0_data_o), .m0_rw_o(m0_rw_o),
      .m0_valid_o(m0_valid_o), .m0_drop_o(m0_drop_o),
      .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_rw_i(m1_rw_i),
      .m1_valid_i(m1_valid_i), .m1_data_o(m1_data_o), .m1_rw_o(m1_rw_o),
      .m1_valid_o(m1_valid_o), .m1_drop_o(m1_drop_o),
      .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o), .bus_rw_o(bus_rw_o),
      .bus_valid_o(bus_valid_o),
      .ret_addr_i(ret_addr_i), .ret_data_i(ret_data_i), .ret_rw_i(ret_rw_i),
      .ret_valid_i(ret_valid_i), .timeout_o(timeout_o)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit          md_pend [2];
   logic [15:0] md_paddr [2];
   logic [15:0] md_pdata [2];
   logic        md_prw [2];
   bit          md_busy;
   int          md_owner, md_last, md_wait;
   logic [15:0] e_bus_addr, e_bus_data;
   logic        e_bus_rw, e_bus_valid;
   logic [15:0] e_m_data [2];
   logic        e_m_rw [2];
   logic        e_m_valid [2];
   logic        e_drop [2];
   logic        e_timeout;
   logic [17:0] exp_q[$];

   task automatic respond(input int o, input logic [15:0] d, input logic r);
      e_m_data[o]  = d;
      e_m_rw[o]    = r;
      e_m_valid[o] = 1'b1;
      md_busy      = 1'b0;
      exp_q.push_back({o[0], d, r});
   endtask

   always @(posedge clk) begin : model
      int          g;
      logic        in_v [2];
      logic [15:0] in_a [2];
      logic [15:0] in_d [2];
      logic        in_r [2];
      in_v[0] = m0_valid_i; in_a[0] = m0_addr_i; in_d[0] = m0_data_i; in_r[0] = m0_rw_i;
      in_v[1] = m1_valid_i; in_a[1] = m1_addr_i; in_d[1] = m1_data_i; in_r[1] = m1_rw_i;
      if (!rst_n) begin
         md_busy = 0; md_last = 1; md_owner = 0; md_wait = 0;
         e_bus_addr = 0; e_bus_data = 0; e_bus_rw = 0; e_bus_valid = 0; e_timeout = 0;
         for (int i = 0; i < 2; i++) begin
            md_pend[i] = 0; e_m_data[i] = 0; e_m_rw[i] = 0; e_m_valid[i] = 0; e_drop[i] = 0;
         end
      end else begin
         e_bus_valid = 0; e_timeout = 0; e_m_valid[0] = 0; e_m_valid[1] = 0;
         g = -1;
         if (md_busy) begin
            if (ret_valid_i) respond(md_owner, ret_data_i, ret_rw_i);
`ifdef ARB_TIMEOUT_EN
            else if (md_wait + 1 == TO) begin
               respond(md_owner, 16'h0000, e_bus_rw);
               e_timeout = 1;
            end else md_wait++;
`endif
         end else begin
            if (md_pend[0] && md_pend[1]) g = 1 - md_last;
            else if (md_pend[0]) g = 0;
            else if (md_pend[1]) g = 1;
            if (g >= 0) begin
               e_bus_addr = md_paddr[g]; e_bus_data = md_pdata[g]; e_bus_rw = md_prw[g];
               e_bus_valid = 1; md_pend[g] = 0; md_busy = 1;
               md_owner = g; md_last = g; md_wait = 0;
            end
         end
         for (int i = 0; i < 2; i++) begin
            if (in_v[i]) begin
               if (md_pend[i]) e_drop[i] = 1;
               else begin
                  md_pend[i] = 1; md_paddr[i] = in_a[i]; md_pdata[i] = in_d[i]; md_prw[i] = in_r[i];
               end
            end
         end
      end
   end

   // ---------------- compare every cycle ----------------
   always @(negedge clk) begin
      logic [17:0] e;
      check("bus_valid", 32'(bus_valid_o), 32'(e_bus_valid));
      check("bus_addr",  32'(bus_addr_o),  32'(e_bus_addr));
      check("bus_data",  32'(bus_data_o),  32'(e_bus_data));
      check("bus_rw",    32'(bus_rw_o),    32'(e_bus_rw));
      check("m0_valid",  32'(m0_valid_o),  32'(e_m_valid[0]));
      check("m0_data",   32'(m0_data_o),   32'(e_m_data[0]));
      check("m0_rw",     32'(m0_rw_o),     32'(e_m_rw[0]));
      check("m0_drop",   32'(m0_drop_o),   32'(e_drop[0]));
      check("m1_valid",  32'(m1_valid_o),  32'(e_m_valid[1]));
      check("m1_data",   32'(m1_data_o),   32'(e_m_data[1]));
      check("m1_rw",     32'(m1_rw_o),     32'(e_m_rw[1]));
      check("m1_drop",   32'(m1_drop_o),   32'(e_drop[1]));
      check("timeout",   32'(timeout_o),   32'(e_timeout));
      if (m0_valid_o === 1'b1 || m1_valid_o === 1'b1) begin
         check("rsp_sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rsp_sb", 32'({m1_valid_o, (m1_valid_o ? m1_data_o : m0_data_o),
                                 (m1_valid_o ? m1_rw_o : m0_rw_o)}), 32'(e));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      m0_valid_i = 0; m1_valid_i = 0; ret_valid_i = 0;
   endtask

   task automatic do_reset();
      rst_n = 0;
      tick();
      tick();
      rst_n = 1;
   endtask

   task automatic req(input int m, input logic [15:0] a, input logic [15:0] d, input logic r);
      if (m == 0) begin m0_addr_i = a; m0_data_i = d; m0_rw_i = r; m0_valid_i = 1; end
      else        begin m1_addr_i = a; m1_data_i = d; m1_rw_i = r; m1_valid_i = 1; end
   endtask

   task automatic ret(input logic [15:0] d, input logic r);
      ret_addr_i = 16'hFFFF; ret_data_i = d; ret_rw_i = r; ret_valid_i = 1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 0;
      m0_addr_i = 0; m0_data_i = 0; m0_rw_i = 0; m0_valid_i = 0;
      m1_addr_i = 0; m1_data_i = 0; m1_rw_i = 0; m1_valid_i = 0;
      ret_addr_i = 0; ret_data_i = 0; ret_rw_i = 0; ret_valid_i = 0;

      // reset state
      tick(); tick();
      @(negedge clk);
      check("rst_bus_valid", 32'(bus_valid_o), 0);
      check("rst_bus_addr", 32'(bus_addr_o), 0);
      check("rst_m0_drop", 32'(m0_drop_o), 0);
      check("rst_timeout", 32'(timeout_o), 0);
      rst_n = 1;

      // single read
      tick(); req(0, 16'h0001, 16'h0000, 0);
      tick(); tick(); @(negedge clk);
      check("rd_bus_valid", 32'(bus_valid_o), 1);
      check("rd_bus_addr", 32'(bus_addr_o), 32'h0001);
      check("rd_bus_rw", 32'(bus_rw_o), 0);
      tick(); tick(); tick(); ret(16'h00A5, 0);
      tick(); @(negedge clk);
      check("rd_m0_valid", 32'(m0_valid_o), 1);
      check("rd_m0_data", 32'(m0_data_o), 32'h00A5);
      check("rd_m1_valid", 32'(m1_valid_o), 0);

      // tie and round-robin
      do_reset();
      tick(); req(0, 16'h0010, 16'h1111, 1); req(1, 16'h0020, 16'h2222, 0);
      tick(); tick(); @(negedge clk);
      check("rr1_addr", 32'(bus_addr_o), 32'h0010);
      check("rr1_rw", 32'(bus_rw_o), 1);
      ret(16'h0B0B, 1);
      tick(); @(negedge clk);
      check("rr1_m0_data", 32'(m0_data_o), 32'h0B0B);
      check("rr1_m1_valid", 32'(m1_valid_o), 0);
      req(0, 16'h0011, 16'h3333, 0);
      tick(); @(negedge clk);
      check("rr2_addr", 32'(bus_addr_o), 32'h0020);
      ret(16'h0C0C, 0);
      tick(); @(negedge clk);
      check("rr2_m1_data", 32'(m1_data_o), 32'h0C0C);
      check("rr2_m0_valid", 32'(m0_valid_o), 0);
      req(1, 16'h0021, 16'h4444, 1);
      tick(); @(negedge clk);
      check("rr3_addr", 32'(bus_addr_o), 32'h0011);
      ret(16'h0D0D, 0);
      tick(); tick(); @(negedge clk);
      check("rr4_addr", 32'(bus_addr_o), 32'h0021);
      ret(16'h0E0E, 1);
      tick(); @(negedge clk);
      check("rr4_m1_valid", 32'(m1_valid_o), 1);

      // new request in the grant cycle
      do_reset();
      tick(); req(0, 16'h0001, 16'h0000, 0);
      tick(); req(0, 16'h0002, 16'h0000, 0);
      tick(); @(negedge clk);
      check("sg1_addr", 32'(bus_addr_o), 32'h0001);
      ret(16'h0101, 0);
      tick(); tick(); @(negedge clk);
      check("sg2_addr", 32'(bus_addr_o), 32'h0002);
      check("sg_drop", 32'(m0_drop_o), 0);
      ret(16'h0202, 0);
      tick();

      // overflow on m1 while m0 is outstanding
      do_reset();
      tick(); req(0, 16'h0030, 16'h0000, 0);
      tick(); tick(); req(1, 16'h0040, 16'h5555, 1);
      tick(); req(1, 16'h0041, 16'h6666, 1);
      tick(); req(1, 16'h0042, 16'h7777, 1);
      tick(); @(negedge clk);
      check("ov_drop", 32'(m1_drop_o), 1);
      ret(16'h0303, 0);
      tick(); tick(); @(negedge clk);
      check("ov_addr", 32'(bus_addr_o), 32'h0040);
      ret(16'h0404, 1);
      tick(); tick(); tick(); @(negedge clk);
      check("ov_no_second", 32'(bus_valid_o), 0);
      check("ov_drop_sticky", 32'(m1_drop_o), 1);

`ifdef ARB_TIMEOUT_EN
      // timeout
      do_reset();
      tick(); req(1, 16'h0004, 16'h0003, 1);
      tick(); tick();
      for (int i = 0; i < TO; i++) tick();
      @(negedge clk);
      check("to_m1_valid", 32'(m1_valid_o), 1);
      check("to_pulse", 32'(timeout_o), 1);
      check("to_data", 32'(m1_data_o), 0);
      check("to_rw", 32'(m1_rw_o), 1);
      tick(); tick(); ret(16'hBEEF, 0);
      tick(); @(negedge clk);
      check("to_late_ignored", 32'(m1_valid_o), 0);
`endif

      // reset in WAIT
      do_reset();
      tick(); req(0, 16'h0050, 16'h0000, 0);
      tick(); tick(); tick();
      rst_n = 0;
      tick();
      rst_n = 1;
      ret(16'h9999, 0);
      tick(); @(negedge clk);
      check("rw_m0_valid", 32'(m0_valid_o), 0);
      check("rw_m1_valid", 32'(m1_valid_o), 0);
      req(0, 16'h0060, 16'h0000, 0); req(1, 16'h0070, 16'h0000, 0);
      tick(); tick(); @(negedge clk);
      check("rw_tie_addr", 32'(bus_addr_o), 32'h0060);
      ret(16'h0606, 0);
      tick(); tick(); tick(); ret(16'h0707, 0);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         tick();
         rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
         if ($urandom_range(0, 3) == 0)
            req(0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0)
            req(1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
         if (md_busy ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0))
            ret(16'($urandom), 1'($urandom_range(0, 1)));
      end
      rst_n = 1;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (md_busy) ret(16'h1234, 0);
      end
      @(negedge clk);
      check("rsp_sb_drained", 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/manta_bus_arbiter.md
# manta_bus_arbiter

Two-master arbiter for the 16-bit Manta register bus. It sits between the UART `bridge_rx`/`bridge_tx` pair (master 0) and a second on-chip requester (master 1), such as a scripted self-test or config loader, and the daisy-chained core bus. It buffers one single-cycle request per master and grants them round-robin, one transaction outstanding at a time. It routes each transaction returning from the end of the core chain back to the master that issued it.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: cycles spent in WAIT before a transaction is abandoned. Only used with `ARB_TIMEOUT_EN`. Range 1..65535.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `m0_addr_i`, `m0_data_i`  in  16 each  master 0 request address and write data.
- `m0_rw_i`  in  1  request type; 1 = write, 0 = read.
- `m0_valid_i`  in  1  single-cycle request pulse.
- `m0_data_o`  out  16  response data.
- `m0_rw_o`  out  1  response type.
- `m0_valid_o`  out  1  single-cycle response pulse.
- `m0_drop_o`  out  1  sticky; set when a master 0 request is lost to overflow.
- `m1_*`: same seven ports for master 1.
- `bus_addr_o`, `bus_data_o`  out  16 each  address and data driven to the core chain.
- `bus_rw_o`  out  1  transaction type to the core chain.
- `bus_valid_o`  out  1  transaction pulse to the core chain.
- `ret_addr_i`, `ret_data_i`  in  16 each  transaction returning from the end of the core chain.
- `ret_rw_i`, `ret_valid_i`  in  1 each  returning type and valid.
- `timeout_o`  out  1  single-cycle pulse when a transaction is abandoned.

## Operation
- Each master has a one-entry pending buffer (addr, data, rw, `pend` flag).
  - A `mX_valid_i` pulse with `pend` clear loads the buffer.
  - A pulse with `pend` set is discarded and sets `mX_drop_o`.
  - A pulse arriving in the same cycle the buffer is granted is accepted: clear and load together leave `pend` = 1.
- `mX_drop_o` is cleared only by reset.
- State machine: IDLE, WAIT.
  - IDLE with exactly one `pend` set: grant that master.
  - IDLE with both set: grant the master that is not `last_grant`.
  - On grant: register its buffer onto `bus_*`, pulse `bus_valid_o`, clear its `pend`, store `owner` and `last_grant`, go to WAIT.
  - WAIT with `ret_valid_i`: copy `ret_data_i`/`ret_rw_i` to `m[owner]_data_o`/`_rw_o`, pulse `m[owner]_valid_o`, go to IDLE.
- Both reads and writes return, because cores pass every transaction through. Writes are forwarded with rw = 1; `bridge_tx` ignores them.
- `ret_valid_i` while in IDLE (stray return, or a late return after timeout or reset) is ignored.
- `ret_addr_i` is not checked; ownership is implied by there being only one outstanding transaction.
- `bus_addr_o`, `bus_data_o` and `bus_rw_o` hold their last value between grants. `mX_data_o` and `mX_rw_o` hold until the next response to that master.

## Timing
- Reset values:
  - All `*_valid_o`, `mX_drop_o`, `timeout_o`: 0.
  - All data/address/rw outputs: 0.
  - Both `pend` flags: 0; state IDLE.
  - `last_grant` = 1, so master 0 wins the first tie.
- Reset mid-WAIT abandons the transaction. No response is issued, and its return is then ignored in IDLE.
- Request to bus: `mX_valid_i` in cycle N, `pend` set at end of N, grant in N+1, `bus_valid_o` high in cycle N+2.
- Return to response: `ret_valid_i` in cycle R gives `m[owner]_valid_o` high in cycle R+1.
- WAIT is entered on the same edge that raises `bus_valid_o`. A `ret_valid_i` in that same cycle is accepted.
- After a response, the earliest next `bus_valid_o` is 2 cycles later (IDLE then grant). Back-to-back `bus_valid_o` is impossible.
- All `*_valid_o` outputs and `timeout_o` are high for exactly one cycle.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When the count reaches `TIMEOUT_CYCLES` with no `ret_valid_i`, the next cycle pulses `m[owner]_valid_o` with data 16'h0000 and rw = the issued rw. `timeout_o` pulses in that same cycle, and the state returns to IDLE.
  - If `ret_valid_i` arrives in the final WAIT cycle, the return wins and no timeout is flagged.
- Undefined: no counter; `timeout_o` is tied to 0 and WAIT persists until `ret_valid_i`.

## Test plan
- Single read: m0 reads 0x0001 at cycle 10; return at cycle 15 with data 0x00A5 -> `bus_valid_o` high at cycle 12 with addr 0x0001, rw 0; `m0_valid_o` high at cycle 16 with data 0x00A5, rw 0; `m1_valid_o` stays 0.
- Tie, round-robin: after reset, m0 and m1 pulse in the same cycle, and both pulse again after their responses -> grant order m0, m1, m0, m1; each response goes only to its issuer.
- Overflow: m1 pulses 3 times while m0's transaction is in WAIT -> first m1 request kept, `m1_drop_o` = 1 and stays 1; only one m1 transaction reaches the bus.
- Simultaneous grant and new request: m0 pulses addr 0x0002 in the cycle its pending 0x0001 is granted -> both appear on the bus in order; `m0_drop_o` stays 0.
- Timeout (`ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 8): m1 write 0x0004 = 0x0003 with no return -> `m1_valid_o` and `timeout_o` high together after 8 WAIT cycles, data 0x0000, rw 1. A late `ret_valid_i` 2 cycles later is ignored.
- Reset mid-WAIT: `rst_n` low for 1 cycle during WAIT, then a return arrives -> no `mX_valid_o`; the next tie grants m0.
